// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Opcodes, status bit indices, instruction fields, FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_OP_PASS = 4'd0;
  localparam logic [3:0] ALU_OP_ADD  = 4'd1;
  localparam logic [3:0] ALU_OP_ADC  = 4'd2;
  localparam logic [3:0] ALU_OP_SUB  = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [3:0] ALU_OP_OR   = 4'd5;
  localparam logic [3:0] ALU_OP_XOR  = 4'd6;
  localparam logic [3:0] ALU_OP_SHL  = 4'd7;
  localparam logic [3:0] ALU_OP_SHR  = 4'd8;
  localparam logic [3:0] ALU_OP_LAST = ALU_OP_SHR;
  localparam logic [3:0] OP_LDI      = 4'd15;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 12;
  localparam int OP_W    = 4;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } seq_state_e;

  function automatic logic is_alu_op(
    input logic [3:0] op
  );
    return op <= ALU_OP_LAST;
  endfunction

  function automatic logic is_ldi(
    input logic [3:0] op
  );
    return op == OP_LDI;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake between fetch and the sequencer.
// Master offers instructions, slave signals readiness.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );

endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// Register file for the ALU sequencer.
// Three combinational reads, one synchronous write.
module alu_seq_regfile #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 8,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rs1_data = mem[rs1_addr];
  assign rs2_data = mem[rs2_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues register-file instructions to a registered ALU and
// writes the result and status back after ALU_LAT cycles.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 8,
  parameter  int ALU_LAT = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   instr_if,
  output logic [3:0]          alu_fsel,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [3:0]          alu_sreg,
  output logic [3:0]          sreg_out,
  output logic                busy,
  output logic                illegal,
  input  logic [AW-1:0]       dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam int CW = 3;

  seq_state_e state;
  seq_state_e state_nxt;

  logic [CW-1:0]     cnt;
  logic [AW-1:0]     rd_q;
  logic [OP_W-1:0]   op;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [DATA_W-1:0] imm;
  logic              accept;
  logic              op_alu;
  logic              op_ldi;
  logic              op_ill;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign op  = instr_if.instr[OP_LSB +: OP_W];
  assign rd  = instr_if.instr[RD_LSB +: AW];
  assign rs1 = instr_if.instr[RS1_LSB +: AW];
  assign rs2 = instr_if.instr[RS2_LSB +: AW];
  assign imm = DATA_W'(instr_if.instr[IMM_LSB +: IMM_W]);

  assign op_alu = is_alu_op(op);
  assign op_ldi = is_ldi(op);
  assign op_ill = !op_alu && !op_ldi;

  assign instr_if.instr_ready = (state == IDLE);
  assign accept = instr_if.instr_valid && instr_if.instr_ready;
  assign busy   = (state == ISSUE) || (state == WB);

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_waddr  = rd_q;
    rf_wdata  = alu_result;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            op_alu: state_nxt = ISSUE;
            op_ldi: begin
              rf_we    = 1'b1;
              rf_waddr = rd;
              rf_wdata = imm;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      ISSUE: begin
        if (cnt == '0) begin
          state_nxt = WB;
        end
      end
      WB: begin
        rf_we     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched at acceptance so a writeback to rs1/rs2 is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_fsel <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      sreg_out <= '0;
      illegal  <= 1'b0;
    end else begin
      illegal <= accept && op_ill;
      if (accept && op_alu) begin
        alu_fsel <= op;
        alu_a    <= rs1_data;
        alu_b    <= rs2_data;
        rd_q     <= rd;
        cnt      <= CW'(ALU_LAT - 1);
      end else if (state == ISSUE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == WB) begin
        sreg_out <= alu_sreg;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer at ALU_LAT 1 and 3.
// Registered add model stands in for the ALU.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;

  alu_op_sequencer_if bus ();
  logic [3:0] fsel;
  logic [7:0] a, b, res, dbg;
  logic [3:0] sreg_in, sreg;
  logic       busy, ill;
  logic [2:0] dbg_addr;

  alu_op_sequencer_if bus3 ();
  logic [3:0] fsel3;
  logic [7:0] a3, b3, res3, dbg3;
  logic [3:0] sreg_in3, sreg3;
  logic       busy3, ill3;
  logic [2:0] dbg_addr3;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.DATA_W(8), .NREGS(8), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_if(bus),
    .alu_fsel(fsel), .alu_a(a), .alu_b(b),
    .alu_result(res), .alu_sreg(sreg_in), .sreg_out(sreg),
    .busy(busy), .illegal(ill),
    .dbg_addr(dbg_addr), .dbg_data(dbg)
  );

  alu_op_sequencer #(.DATA_W(8), .NREGS(8), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .instr_if(bus3),
    .alu_fsel(fsel3), .alu_a(a3), .alu_b(b3),
    .alu_result(res3), .alu_sreg(sreg_in3), .sreg_out(sreg3),
    .busy(busy3), .illegal(ill3),
    .dbg_addr(dbg_addr3), .dbg_data(dbg3)
  );

  // ALU models: sum of operands; op 3 reports status 4'b1010.
  logic [7:0] p1, p2;
  logic [3:0] s1, s2;
  always @(posedge clk) begin
    res     <= a + b;
    sreg_in <= (fsel == 4'd3) ? 4'b1010 : 4'b0000;
    p1       <= a3 + b3;
    p2       <= p1;
    res3     <= p2;
    s1       <= (fsel3 == 4'd3) ? 4'b1010 : 4'b0000;
    s2       <= s1;
    sreg_in3 <= s2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  rd;
    logic [7:0]  exp_rd;
    logic [3:0]  exp_sreg;
    int          exp_low;
    logic        is_alu;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [3:0]  exp_fsel;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] ad, output logic [7:0] v);
    dbg_addr = ad;
    #1;
    v = dbg;
  endtask

  task automatic send(input logic [15:0] w);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic apply(input int i, input vec_t v);
    int n;
    logic [7:0] r;
    send(v.instr);
    if (v.is_alu) begin
      chk($sformatf("v%0d_fsel", i), 32'(fsel), 32'(v.exp_fsel));
      chk($sformatf("v%0d_a", i), 32'(a), 32'(v.exp_a));
      chk($sformatf("v%0d_b", i), 32'(b), 32'(v.exp_b));
    end
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      n++;
      step();
    end
    chk($sformatf("v%0d_low", i), 32'(n), 32'(v.exp_low));
    peek(v.rd, r);
    chk($sformatf("v%0d_rd", i), 32'(r), 32'(v.exp_rd));
    chk($sformatf("v%0d_sreg", i), 32'(sreg), 32'(v.exp_sreg));
  endtask

  initial begin
    logic [7:0] r;
    logic [8:0] rdy_pat, bsy_pat;
    logic held;
    int n;

    tbl[0] = '{16'hF206, 3'd1, 8'h06, 4'h0, 0, 1'b0, 8'h00, 8'h00, 4'h0};
    tbl[1] = '{16'hF409, 3'd2, 8'h09, 4'h0, 0, 1'b0, 8'h00, 8'h00, 4'h0};
    tbl[2] = '{16'h1650, 3'd3, 8'h0F, 4'h0, 2, 1'b1, 8'h06, 8'h09, 4'h1};
    tbl[3] = '{16'hF27F, 3'd1, 8'h7F, 4'h0, 0, 1'b0, 8'h00, 8'h00, 4'h0};
    tbl[4] = '{16'hF47D, 3'd2, 8'h7D, 4'h0, 0, 1'b0, 8'h00, 8'h00, 4'h0};
    tbl[5] = '{16'h3850, 3'd4, 8'hFC, 4'hA, 2, 1'b1, 8'h7F, 8'h7D, 4'h3};
    tbl[6] = '{16'h1248, 3'd1, 8'hFE, 4'h0, 2, 1'b1, 8'h7F, 8'h7F, 4'h1};
    tbl[7] = '{16'h1A48, 3'd5, 8'hFC, 4'h0, 2, 1'b1, 8'hFE, 8'hFE, 4'h1};
    tbl[8] = '{16'hF0AA, 3'd0, 8'hAA, 4'h0, 0, 1'b0, 8'h00, 8'h00, 4'h0};
    tbl[9] = '{16'h2C10, 3'd6, 8'h27, 4'h0, 2, 1'b1, 8'hAA, 8'h7D, 4'h2};

    rst_n = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.instr        = '0;
    bus3.instr_valid = 1'b0;
    bus3.instr       = '0;
    dbg_addr  = '0;
    dbg_addr3 = '0;
    #12 rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ill", 32'(ill), 32'd0);
    chk("rst_fsel", 32'(fsel), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_sreg", 32'(sreg), 32'd0);

    // ALU_LAT=3: back-to-back LDIs, then a 4-cycle hold
    dbg_addr3 = 3'd3;
    bus3.instr_valid = 1'b1;
    bus3.instr = 16'hF206;
    step();
    bus3.instr = 16'hF409;
    step();
    bus3.instr = 16'h1650;
    step();
    bus3.instr_valid = 1'b0;
    held = 1'b1;
    n = 0;
    while (!bus3.instr_ready && n < 20) begin
      if (a3 !== 8'h06 || b3 !== 8'h09 || fsel3 !== 4'h1) held = 1'b0;
      if (n == 3) chk("lat3_wb_old", 32'(dbg3), 32'h0);
      n++;
      step();
    end
    chk("lat3_low", 32'(n), 32'd4);
    chk("lat3_hold", 32'(held), 32'd1);
    chk("lat3_r3", 32'(dbg3), 32'h0F);
    dbg_addr3 = 3'd2;
    #1;
    chk("lat3_r2", 32'(dbg3), 32'h09);

    // Mid-op reset
    send(16'hF206);
    send(16'h1648);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(bus.instr_ready), 32'd1);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_a", 32'(a), 32'd0);
    chk("mid_fsel", 32'(fsel), 32'd0);
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), r);
      chk($sformatf("mid_r%0d", i), 32'(r), 32'd0);
    end
    bus.instr = 16'hFA55;
    bus.instr_valid = 1'b1;
    step();
    step();
    bus.instr_valid = 1'b0;
    #3 rst_n = 1'b1;
    step();
    step();
    step();
    peek(3'd3, r);
    chk("mid_r3_after", 32'(r), 32'd0);
    peek(3'd5, r);
    chk("mid_r5_after", 32'(r), 32'd0);

    // Table-driven sequence
    for (int i = 0; i < 10; i++) begin
      apply(i, tbl[i]);
    end

    // Illegal opcode 9 with rd=r3, imm=AB
    send(16'h96AB);
    chk("ill_pulse", 32'(ill), 32'd1);
    chk("ill_ready", 32'(bus.instr_ready), 32'd1);
    step();
    chk("ill_clear", 32'(ill), 32'd0);
    peek(3'd3, r);
    chk("ill_r3", 32'(r), 32'h0F);
    chk("ill_sreg", 32'(sreg), 32'h0);
    chk("ill_fsel", 32'(fsel), 32'h2);

    // Back-to-back op2 r7=r1+r2 with valid held high
    dbg_addr = 3'd7;
    #1;
    bus.instr = 16'h2E50;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rdy_pat[k] = bus.instr_ready;
      bsy_pat[k] = busy;
      if (k == 2) chk("b2b_wb_old", 32'(dbg), 32'h00);
      if (k == 3) chk("b2b_wb_new", 32'(dbg), 32'h7B);
      step();
    end
    bus.instr_valid = 1'b0;
    chk("b2b_ready", 32'(rdy_pat), 32'h049);
    chk("b2b_busy", 32'(bsy_pat), 32'h1B6);
    step();
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_r7", 32'(dbg), 32'h7B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Instruction-driven initiator for the ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8-entry register file. It drives the ALU's function-select and operand inputs, waits the ALU's registered latency, then writes the result and the 4-bit status (SREG) back. It sits between the future fetch stage and the existing ALU.

## Interface
- `DATA_W`, default 8: operand/result width.
- `NREGS`, default 8: register-file depth (address width `$clog2(NREGS)`, 3 at default).
- `ALU_LAT`, default 1: ALU cycles from operand capture to a valid `alu_result`; legal range 1..7.

- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept an instruction; equals (state == IDLE).
- `instr`  in  16  instruction word, with fields:
  - `[15:12]` op
  - `[11:9]` rd
  - `[8:6]` rs1
  - `[5:3]` rs2
  - `[7:0]` imm, used only when op is LDI
- `alu_fsel`  out  4  function select to the ALU.
- `alu_a`, `alu_b`  out  DATA_W  operands to the ALU.
- `alu_result`  in  DATA_W  ALU output.
- `alu_sreg`  in  4  ALU status.
- `sreg_out`  out  4  last captured status.
- `busy`  out  1  ALU operation in flight (state ISSUE or WB).
- `illegal`  out  1  one-cycle pulse when an undefined opcode is accepted.
- `dbg_addr`  in  3  register-file read address.
- `dbg_data`  out  DATA_W  combinational read of `reg[dbg_addr]`.

## Operation
- Opcodes:
  - 0..8 are ALU ops and are forwarded unchanged on `alu_fsel`; the sequencer does not interpret them.
  - 15 is LDI.
  - 9..14 are illegal.
- Acceptance: an instruction is accepted on a rising edge where `instr_valid && instr_ready`.
- States:
  - IDLE
    - Accepting an ALU op goes to ISSUE.
    - Accepting LDI writes `reg[rd] = imm` on the accepting edge and stays in IDLE.
    - Accepting an illegal op asserts `illegal` for the following cycle, stays in IDLE, and changes no register or `sreg_out`.
  - ISSUE: lasts exactly ALU_LAT cycles, timed by a down-counter. `alu_fsel`, `alu_a` and `alu_b` are held constant throughout.
  - WB: lasts one cycle. On its closing edge, `reg[rd]` is written with `alu_result` and `sreg_out` with `alu_sreg`. Next state is IDLE.
- Operand registers:
  - On the accepting edge of an ALU op: `alu_a <= reg[rs1]`, `alu_b <= reg[rs2]`, `alu_fsel <= op`.
  - These registers hold their value after WB until the next ALU op is accepted.
- `rd == rs1/rs2` is legal. Operands are latched at acceptance, so the writeback cannot corrupt them.
- Any write to r0 is allowed; r0 is an ordinary register, not hardwired.
- Results are truncated to DATA_W. No sign or width handling occurs here.

## Timing
- Accept edge E0:
  - The ALU sees valid operands from E0 through E0+ALU_LAT+1.
  - Writeback happens at E0+ALU_LAT+1; `instr_ready` rises after that edge.
  - The next accept is at E0+ALU_LAT+2 at the earliest.
  - Throughput is therefore one ALU op per ALU_LAT+2 cycles.
- LDI: one cycle each; back-to-back LDIs are accepted on consecutive edges.
- `dbg_data` during the WB cycle shows the old `reg[rd]`; the new value appears the cycle after.
- Reset values:
  - state IDLE, so `instr_ready` = 1
  - all registers 0
  - `alu_fsel` = 0, `alu_a` = 0, `alu_b` = 0
  - `sreg_out` = 0, `busy` = 0, `illegal` = 0
- Reset mid-operation: assertion immediately aborts the in-flight op with no writeback. No instruction is accepted while `rst_n` is low.
- `instr` is ignored whenever `instr_ready` is 0.

## Structure
- Package `alu_pkg` holds:
  - the `ALU_OP_*` localparams 0..8 and `OP_LDI` = 15
  - the SREG bit indices: `SREG_C`=0, `SREG_Z`=1, `SREG_N`=2, `SREG_V`=3
  - the instruction field positions
  - the state enum IDLE/ISSUE/WB
- Sub-module `alu_seq_regfile`:
  - NREGS×DATA_W storage with async reset
  - ports: three combinational read ports (rs1, rs2, dbg) and one synchronous write port
- The sequencer core holds the FSM, latency counter and operand registers.

## Test plan
- Mid-op reset: LDI r1=6, then op1 r3=r1,r1; drop `rst_n` during ISSUE → all outputs 0, `instr_ready`=1, `dbg_data` 0 for every address, r3 never written.
- Basic ALU op (ALU model: registered A+B, sreg 4'b0000): LDI r1=6, LDI r2=9, op1 r3=r1,r2 → `alu_fsel`=1, `alu_a`=6, `alu_b`=9, `instr_ready` low for exactly 2 cycles, r3=15.
- Back-to-back: `instr_valid` held high with three op2 instructions → accepts exactly 3 cycles apart; `busy` high 2 of every 3 cycles.
- Illegal op 9 while r3=15 and `sreg_out`=4'b0000 → `illegal` high exactly 1 cycle; r3=15 and `sreg_out` unchanged; `instr_ready` stays 1.
- Status capture: model returns sreg 4'b1010 for op3 with r1=127, r2=125 → `alu_a`=127, `alu_b`=125, `sreg_out`=4'b1010 after WB.
- ALU_LAT=3 → operands held 4 cycles, writeback at E0+4, next accept no earlier than E0+5.
